// File: rtl/chipset_pkg.sv
// chipset_pkg: shared types and constants for the chipset_nregions interconnect.
//   - state_t          : access FSM states (IDLE / ACCESS / RESP)
//   - ERR_STATUS_OFS   : CSR offset of the sticky error status register
//   - ERR_ADDR_OFS     : CSR offset of the captured error address
//   - ERR_*_BIT        : bit positions inside ERR_STATUS
//   - err_status_next  : W1C plus error-set update of ERR_STATUS
package chipset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int unsigned ERR_STATUS_OFS = 32'h40;
  localparam int unsigned ERR_ADDR_OFS   = 32'h44;

  localparam int ERR_VALID_BIT   = 0;
  localparam int ERR_TIMEOUT_BIT = 1;
  localparam int ERR_OVF_BIT     = 2;

  // Clear first, then apply a new error so that a same-cycle error survives the W1C.
  function automatic logic [2:0] err_status_next(input logic [2:0] cur,
                                                 input logic [2:0] clr,
                                                 input logic       set,
                                                 input logic       is_timeout);
    logic [2:0] nxt;
    nxt = cur & ~clr;
    if (set) begin
      if (nxt[ERR_VALID_BIT]) begin
        nxt[ERR_OVF_BIT] = 1'b1;
      end else begin
        nxt[ERR_VALID_BIT]   = 1'b1;
        nxt[ERR_TIMEOUT_BIT] = is_timeout;
      end
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/chipset_csr.sv
// chipset_csr: CSR window of the interconnect.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_ofs            : byte offset inside the CSR window (read mux / write decode)
//   i_wr_en          : one-cycle strobe, a CSR write is accepted this cycle
//   i_clr_data       : low write-data bits, W1C mask for ERR_STATUS
//   i_err_set        : a bus error completes this cycle
//   i_err_timeout    : cause of that error is a slave timeout (else unmapped)
//   i_err_addr       : full address of the failing access
//   i_ctrl_val       : NUM_CTRL read-only control words
//   o_rdata          : combinational read data for i_ofs
//   o_irq_err        : ERR_STATUS.valid
module chipset_csr
  import chipset_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int NUM_CTRL = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [AW-1:0]          i_ofs,
  input  logic                   i_wr_en,
  input  logic [2:0]             i_clr_data,
  input  logic                   i_err_set,
  input  logic                   i_err_timeout,
  input  logic [AW-1:0]          i_err_addr,
  input  logic [NUM_CTRL*DW-1:0] i_ctrl_val,
  output logic [DW-1:0]          o_rdata,
  output logic                   o_irq_err
);

  logic [2:0]    r_status;
  logic [AW-1:0] r_err_addr;
  logic [2:0]    w_clr;
  logic [2:0]    w_after_clr;
  logic          w_first_err;

  // Read mux: status/address registers, then aligned control words, else zero.
  always_comb begin
    o_rdata = '0;
    if (i_ofs == AW'(ERR_STATUS_OFS)) begin
      o_rdata = DW'(r_status);
    end else if (i_ofs == AW'(ERR_ADDR_OFS)) begin
      o_rdata = DW'(r_err_addr);
    end else if ((i_ofs[1:0] == 2'b00) && (i_ofs < AW'(4 * NUM_CTRL))) begin
      o_rdata = i_ctrl_val[32'(i_ofs[5:2]) * DW +: DW];
    end else begin
      o_rdata = '0;
    end
  end

  // W1C mask and "first error" detection (ERR_ADDR only captures the first one).
  always_comb begin
    w_clr       = 3'b000;
    if (i_wr_en && (i_ofs == AW'(ERR_STATUS_OFS))) begin
      w_clr = i_clr_data;
    end else begin
      w_clr = 3'b000;
    end
    w_after_clr = r_status & ~w_clr;
    w_first_err = i_err_set && !w_after_clr[ERR_VALID_BIT];
  end

  // Sticky error status and address registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status   <= 3'b000;
      r_err_addr <= '0;
    end else begin
      r_status <= err_status_next(r_status, w_clr, i_err_set, i_err_timeout);
      if (w_first_err) begin
        r_err_addr <= i_err_addr;
      end
    end
  end

  assign o_irq_err = r_status[ERR_VALID_BIT];

endmodule

// File: rtl/chipset_nregions.sv
// chipset_nregions: registered memory-map interconnect from the core data port
// to NUM_REGIONS equal-sized slave regions plus a CSR window right after them.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wd: core request, held until o_ack
//   o_rd/o_ack/o_err      : one-cycle response (rd is 0 on writes and errors)
//   o_irq_err             : sticky bus-error flag (ERR_STATUS.valid)
//   o_reg_sel/o_reg_we/o_reg_addr/o_reg_wd : slave side, sel is one-hot
//   i_reg_rd/i_reg_ack    : per-slave read data and completion
//   i_ctrl_val            : read-only control words exposed in the CSR window
module chipset_nregions
  import chipset_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          NUM_REGIONS = 4,
  parameter logic [AW-1:0] BASE      = '0,
  parameter int unsigned REGION_SIZE = 32'h10000,
  parameter int          NUM_CTRL    = 3,
  parameter int          TIMEOUT     = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_addr,
  input  logic [DW-1:0]             i_wd,
  output logic [DW-1:0]             o_rd,
  output logic                      o_ack,
  output logic                      o_err,
  output logic                      o_irq_err,
  output logic [NUM_REGIONS-1:0]    o_reg_sel,
  output logic                      o_reg_we,
  output logic [AW-1:0]             o_reg_addr,
  output logic [DW-1:0]             o_reg_wd,
  input  logic [NUM_REGIONS*DW-1:0] i_reg_rd,
  input  logic [NUM_REGIONS-1:0]    i_reg_ack,
  input  logic [NUM_CTRL*DW-1:0]    i_ctrl_val
);

  localparam int RS_LOG2 = $clog2(REGION_SIZE);
  localparam int IW      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int CW      = $clog2(TIMEOUT + 1);
  // One bit wider than the address so the window ends never wrap.
  localparam logic [AW:0] REG_SPAN = (AW+1)'(NUM_REGIONS * REGION_SIZE);
  localparam logic [AW:0] CSR_END  = REG_SPAN + (AW+1)'(REGION_SIZE);

  state_t                   r_state;
  logic [NUM_REGIONS-1:0]   r_reg_sel;
  logic                     r_reg_we;
  logic [AW-1:0]            r_reg_addr;
  logic [DW-1:0]            r_reg_wd;
  logic [IW-1:0]            r_idx;
  logic [AW-1:0]            r_addr;
  logic [CW-1:0]            r_cnt;
  logic [DW-1:0]            r_rd;
  logic                     r_ack;
  logic                     r_err;

  logic [AW-1:0]            w_off;
  logic                     w_is_region;
  logic                     w_is_csr;
  logic [IW-1:0]            w_idx;
  logic [AW-1:0]            w_reg_ofs;
  logic [AW-1:0]            w_csr_ofs;
  logic                     w_sel_ack;
  logic [DW-1:0]            w_sel_rd;
  logic                     w_timeout;
  logic                     w_err_set;
  logic                     w_err_timeout;
  logic [AW-1:0]            w_err_addr;
  logic                     w_csr_wr;
  logic [DW-1:0]            w_csr_rdata;

  // Address decode of the live request (only used while IDLE).
  always_comb begin
    w_off       = i_addr - BASE;
    w_is_region = (i_addr >= BASE) && ({1'b0, w_off} < REG_SPAN);
    w_is_csr    = (i_addr >= BASE) && !w_is_region && ({1'b0, w_off} < CSR_END);
    w_idx       = IW'(w_off >> RS_LOG2);
    w_reg_ofs   = w_off & AW'(REGION_SIZE - 1);
    w_csr_ofs   = w_off - AW'(REG_SPAN);
  end

  // Selected-slave view; acks from other slaves never reach the FSM.
  always_comb begin
    w_sel_ack = i_reg_ack[r_idx];
    w_sel_rd  = i_reg_rd[32'(r_idx) * DW +: DW];
    w_timeout = (r_cnt == CW'(TIMEOUT));
  end

  // Error and CSR-write strobes towards the CSR block.
  always_comb begin
    w_err_set     = 1'b0;
    w_err_timeout = 1'b0;
    w_err_addr    = i_addr;
    w_csr_wr      = 1'b0;
    if ((r_state == ST_IDLE) && i_req) begin
      w_err_set = !w_is_region && !w_is_csr;
      w_csr_wr  = w_is_csr && i_we;
    end else if ((r_state == ST_ACCESS) && !w_sel_ack && w_timeout) begin
      w_err_set     = 1'b1;
      w_err_timeout = 1'b1;
      w_err_addr    = r_addr;
    end else begin
      w_err_set = 1'b0;
    end
  end

  chipset_csr #(
    .DW       (DW),
    .AW       (AW),
    .NUM_CTRL (NUM_CTRL)
  ) u_csr (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ofs         (w_csr_ofs),
    .i_wr_en       (w_csr_wr),
    .i_clr_data    (i_wd[2:0]),
    .i_err_set     (w_err_set),
    .i_err_timeout (w_err_timeout),
    .i_err_addr    (w_err_addr),
    .i_ctrl_val    (i_ctrl_val),
    .o_rdata       (w_csr_rdata),
    .o_irq_err     (o_irq_err)
  );

  // Access FSM with registered slave-side and core-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_reg_sel  <= '0;
      r_reg_we   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_wd   <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          r_rd  <= '0;
          if (i_req) begin
            r_addr <= i_addr;
            if (w_is_region) begin
              r_state    <= ST_ACCESS;
              r_idx      <= w_idx;
              r_reg_sel  <= NUM_REGIONS'(1'b1) << w_idx;
              r_reg_we   <= i_we;
              r_reg_addr <= w_reg_ofs;
              r_reg_wd   <= i_wd;
              r_cnt      <= '0;
            end else begin
              // CSR and unmapped accesses answer straight away.
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
              r_err   <= !w_is_csr;
              r_rd    <= (w_is_csr && !i_we) ? w_csr_rdata : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (w_sel_ack || w_timeout) begin
            r_state    <= ST_RESP;
            r_ack      <= 1'b1;
            r_err      <= !w_sel_ack;
            r_rd       <= (w_sel_ack && !r_reg_we) ? w_sel_rd : '0;
            r_reg_sel  <= '0;
            r_reg_we   <= 1'b0;
            r_reg_addr <= '0;
            r_reg_wd   <= '0;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rd    <= '0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ack     <= 1'b0;
          r_err     <= 1'b0;
          r_rd      <= '0;
          r_reg_sel <= '0;
        end
      endcase
    end
  end

  assign o_rd       = r_rd;
  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_reg_sel  = r_reg_sel;
  assign o_reg_we   = r_reg_we;
  assign o_reg_addr = r_reg_addr;
  assign o_reg_wd   = r_reg_wd;

endmodule

// File: tb/tb_chipset_nregions.sv
// tb_chipset_nregions: self-checking bench for chipset_nregions
// (NUM_REGIONS=4, REGION_SIZE='h10000, NUM_CTRL=3, TIMEOUT=4).
module tb_chipset_nregions;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wd;
  logic [31:0]  o_rd;
  logic         o_ack;
  logic         o_err;
  logic         o_irq_err;
  logic [3:0]   o_reg_sel;
  logic         o_reg_we;
  logic [31:0]  o_reg_addr;
  logic [31:0]  o_reg_wd;
  logic [127:0] reg_rd;
  logic [3:0]   reg_ack;
  logic [95:0]  ctrl_val;

  int           checks;
  int           errors;
  int           cyc;
  int           lat [4];
  int           sel_cnt [4];
  logic [31:0]  slave_data [4];
  logic         spurious;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs [13];

  chipset_nregions #(
    .DW(32), .AW(32), .NUM_REGIONS(4), .BASE(32'h0), .REGION_SIZE(32'h10000),
    .NUM_CTRL(3), .TIMEOUT(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wd(wd),
    .o_rd(o_rd), .o_ack(o_ack), .o_err(o_err), .o_irq_err(o_irq_err),
    .o_reg_sel(o_reg_sel), .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr), .o_reg_wd(o_reg_wd),
    .i_reg_rd(reg_rd), .i_reg_ack(reg_ack), .i_ctrl_val(ctrl_val)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Per-slave count of consecutive selected cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) sel_cnt[i] <= o_reg_sel[i] ? sel_cnt[i] + 1 : 0;
  end

  // Slave models: combinational ack after lat[i] wait cycles, lat<0 never acks.
  always_comb begin
    reg_ack = '0;
    reg_rd  = '0;
    for (int i = 0; i < 4; i++) begin
      reg_rd[i*32 +: 32] = slave_data[i];
      if (o_reg_sel[i] && (lat[i] >= 0) && (sel_cnt[i] >= lat[i])) reg_ack[i] = 1'b1;
    end
    if (spurious) reg_ack[0] = 1'b1;
  end

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0d %s actual=%h expected=%h", id, nm, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr, input int elat, input int id,
                        output int sel_cycles, output logic [3:0] fsel,
                        output logic [31:0] faddr, output logic fwe, output logic [31:0] fwd);
    exp_t e;
    bit   got;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wd = d;
    sb_q.push_back('{erd, eerr, elat, cyc});
    sel_cycles = 0; fsel = '0; faddr = '0; fwe = 1'b0; fwd = '0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_reg_sel != 4'b0000) begin
        if (sel_cycles == 0) begin
          fsel = o_reg_sel; faddr = o_reg_addr; fwe = o_reg_we; fwd = o_reg_wd;
        end
        sel_cycles++;
      end
      if (o_ack) begin
        got = 1'b1;
        req = 1'b0; we = 1'b0;
        e = sb_q.pop_front();
        chk(id, "rd", o_rd, e.rd);
        chk(id, "err", 32'(o_err), 32'(e.err));
        chk(id, "latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %0d ack_wait actual=none expected=ack", id);
      req = 1'b0;
      e = sb_q.pop_front();
    end else begin
      @(negedge clk);
      chk(id, "ack_one_cycle", 32'(o_ack), 32'd0);
    end
  endtask

  int          sc;
  logic [3:0]  fs;
  logic [31:0] fa;
  logic        fw;
  logic [31:0] fd;
  int          acks;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; spurious = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wd = '0;
    ctrl_val = {32'h3, 32'h2, 32'h1};
    slave_data[0] = 32'h0000A0A0; slave_data[1] = 32'h0000B1B1;
    slave_data[2] = 32'h0000CAFE; slave_data[3] = 32'h0000D3D3;
    for (int i = 0; i < 4; i++) begin lat[i] = 0; sel_cnt[i] = 0; end

    vecs[0]  = '{1'b0, 32'h00040000, 32'h0,    32'h1,      1'b0, 1};
    vecs[1]  = '{1'b0, 32'h00040004, 32'h0,    32'h2,      1'b0, 1};
    vecs[2]  = '{1'b0, 32'h00040008, 32'h0,    32'h3,      1'b0, 1};
    vecs[3]  = '{1'b0, 32'h0004000C, 32'h0,    32'h0,      1'b0, 1};
    vecs[4]  = '{1'b1, 32'h00040000, 32'hFFFF, 32'h0,      1'b0, 1};
    vecs[5]  = '{1'b0, 32'h00040000, 32'h0,    32'h1,      1'b0, 1};
    vecs[6]  = '{1'b0, 32'h00040002, 32'h0,    32'h0,      1'b0, 1};
    vecs[7]  = '{1'b0, 32'h00040040, 32'h0,    32'h0,      1'b0, 1};
    vecs[8]  = '{1'b0, 32'h00040044, 32'h0,    32'h0,      1'b0, 1};
    vecs[9]  = '{1'b0, 32'h00000004, 32'h0,    32'hA0A0,   1'b0, 2};
    vecs[10] = '{1'b0, 32'h0003FFFF, 32'h0,    32'hD3D3,   1'b0, 2};
    vecs[11] = '{1'b1, 32'h00020000, 32'h1234, 32'h0,      1'b0, 2};
    vecs[12] = '{1'b0, 32'h00010000, 32'h0,    32'hB1B1,   1'b0, 2};

    // Reset state.
    rst_n = 1'b0;
    #12;
    chk(0, "rst_rd", o_rd, 32'h0);
    chk(0, "rst_ctl", {27'h0, o_ack, o_err, o_irq_err, o_reg_we, o_reg_sel != 4'b0}, 32'h0);
    chk(0, "rst_reg_addr", o_reg_addr | o_reg_wd, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors.
    for (int v = 0; v < 13; v++) begin
      access(vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].exp_rd, vecs[v].exp_err,
             vecs[v].exp_lat, 100 + v, sc, fs, fa, fw, fd);
    end

    // Region read with combinational ack: select/offset at n+1, data at n+2.
    access(1'b0, 32'h00020010, 32'h0, 32'hCAFE, 1'b0, 2, 200, sc, fs, fa, fw, fd);
    chk(200, "sel", 32'(fs), 32'h4);
    chk(200, "reg_addr", fa, 32'h10);
    chk(200, "sel_cycles", 32'(sc), 32'd1);

    // Wait states on slave 1, with an unselected slave acking spuriously.
    lat[1] = 2; spurious = 1'b1;
    access(1'b1, 32'h0001000C, 32'h5A, 32'h0, 1'b0, 4, 210, sc, fs, fa, fw, fd);
    spurious = 1'b0; lat[1] = 0;
    chk(210, "sel_cycles", 32'(sc), 32'd3);
    chk(210, "sel", 32'(fs), 32'h2);
    chk(210, "reg_we", 32'(fw), 32'd1);
    chk(210, "reg_wd", fd, 32'h5A);
    chk(210, "reg_addr", fa, 32'hC);

    // Timeout on slave 3.
    lat[3] = -1;
    access(1'b0, 32'h00030020, 32'h0, 32'h0, 1'b1, 6, 220, sc, fs, fa, fw, fd);
    lat[3] = 0;
    chk(220, "irq_err", 32'(o_irq_err), 32'd1);
    access(1'b0, 32'h00040040, 32'h0, 32'h3, 1'b0, 1, 221, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00040044, 32'h0, 32'h00030020, 1'b0, 1, 222, sc, fs, fa, fw, fd);
    access(1'b1, 32'h00040040, 32'h7, 32'h0, 1'b0, 1, 223, sc, fs, fa, fw, fd);
    chk(223, "irq_clr", 32'(o_irq_err), 32'd0);

    // Unmapped access twice: first error, then overflow.
    access(1'b0, 32'h00050000, 32'h0, 32'h0, 1'b1, 1, 230, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00040040, 32'h0, 32'h1, 1'b0, 1, 231, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00040044, 32'h0, 32'h00050000, 1'b0, 1, 232, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00050000, 32'h0, 32'h0, 1'b1, 1, 233, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00040040, 32'h0, 32'h5, 1'b0, 1, 234, sc, fs, fa, fw, fd);
    access(1'b0, 32'h00040044, 32'h0, 32'h00050000, 1'b0, 1, 235, sc, fs, fa, fw, fd);
    access(1'b1, 32'h00040040, 32'h7, 32'h0, 1'b0, 1, 236, sc, fs, fa, fw, fd);
    chk(236, "irq_clr", 32'(o_irq_err), 32'd0);
    access(1'b0, 32'h00040040, 32'h0, 32'h0, 1'b0, 1, 237, sc, fs, fa, fw, fd);

    // Reset while in ACCESS: select drops at once, no ack appears.
    lat[0] = -1;
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h8;
    @(negedge clk);
    chk(240, "pre_rst_sel", 32'(o_reg_sel), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk(240, "rst_sel", 32'(o_reg_sel), 32'h0);
    req = 1'b0;
    acks = 0;
    repeat (3) begin @(negedge clk); acks += int'(o_ack); end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); acks += int'(o_ack); end
    chk(240, "no_ack", 32'(acks), 32'd0);
    lat[0] = 0;
    access(1'b0, 32'h00000004, 32'h0, 32'hA0A0, 1'b0, 2, 241, sc, fs, fa, fw, fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
